// File: rtl/mips_prog_loader_pkg.sv
// Shared MIPS32 definitions: loader state encoding, the HLT opcode and
// the helper that recognises an end-of-program word.
package mips_prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } ldr_state_t;

  localparam logic [5:0] HLT_OPCODE = 6'h3F;

  function automatic logic is_hlt(input logic [31:0] word, input logic [5:0] op);
    return (word[31:26] == op);
  endfunction

endpackage

// File: rtl/mips_prog_loader_if.sv
// Byte-source, instruction-memory and processor-control bundle of the loader.
interface mips_prog_loader_if #(parameter int ADDR_W = 10);

  logic              load_req;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              cpu_start;
  logic [ADDR_W:0]   word_count;
  logic              load_err;

  modport slave (
    input  load_req, byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata,
           cpu_hold, cpu_start, word_count, load_err
  );

  modport master (
    output load_req, byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata,
           cpu_hold, cpu_start, word_count, load_err
  );

endinterface

// File: rtl/mips_prog_loader_byte_word_packer.sv
// Packs accepted bytes MSB-first into a 32-bit word; flags the 4th byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_word_done
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sr;
  logic [31:0] w_word_next;

  // Only the first three bytes are held; the 4th completes the word on the fly.
  assign w_word_next = {r_sr, i_byte};
  assign o_word_next = w_word_next;
  assign o_word_done = i_shift && (r_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= 2'd0;
    end else if (i_shift) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_shift) begin
      r_sr <= w_word_next[23:0];
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// Streams a byte-serial program into instruction memory while holding the
// processor, then releases it once the HLT word has been written.
module mips_prog_loader
  import mips_prog_loader_pkg::*;
#(
  parameter int         ADDR_W = 10,
  parameter logic [5:0] HLT_OP = HLT_OPCODE
) (
  input  logic               clk1,
  input  logic               rst,
  mips_prog_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   WC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  ldr_state_t        r_state;
  logic              r_byte_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_hold;
  logic              r_start;
  logic [ADDR_W:0]   r_wc;
  logic              r_err;

  logic              w_shift;
  logic              w_clr;
  logic              w_word_done;
  logic [31:0]       w_word_next;
  logic              w_idle_like;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_shift     = (r_state == ST_LOAD) && bus.byte_valid && r_byte_ready;
  assign w_clr       = w_idle_like && bus.load_req;

  byte_word_packer u_packer (
    .clk         (clk1),
    .rst         (rst),
    .i_clr       (w_clr),
    .i_shift     (w_shift),
    .i_byte      (bus.byte_data),
    .o_word_next (w_word_next),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_hold       <= 1'b1;
      r_start      <= 1'b0;
      r_wc         <= '0;
      r_err        <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.load_req) begin
            r_state      <= ST_LOAD;
            r_addr       <= '0;
            r_wc         <= '0;
            r_err        <= 1'b0;
            r_hold       <= 1'b1;
            r_byte_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_word_done) begin
            r_state      <= ST_COMMIT;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b1;
            r_wdata      <= w_word_next;
          end
        end
        ST_COMMIT: begin
          r_wc <= r_wc + WC_ONE;
          if (is_hlt(r_wdata, HLT_OP)) begin
            r_state <= ST_DONE;
            r_start <= 1'b1;
            r_hold  <= 1'b0;
          end else if (r_addr == ADDR_MAX) begin
            // Memory full without a HLT word: refuse to run the program.
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end else begin
            r_state      <= ST_LOAD;
            r_addr       <= r_addr + ADDR_ONE;
            r_byte_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.cpu_hold   = r_hold;
  assign bus.cpu_start  = r_start;
  assign bus.word_count = r_wc;
  assign bus.load_err   = r_err;

endmodule
